// File: rtl/div_arbiter.sv
// Round-robin front end for one shared iterative divider (RISC-V DIV/DIVU/REM/REMU).
// Resolves divide-by-zero and signed overflow locally and reuses the last divider result.
module div_arbiter #(
    parameter int unsigned NUM_BITS = 32,
    parameter int unsigned NUM_REQ  = 2
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_REQ-1:0]          req_valid,
    output logic [NUM_REQ-1:0]          req_ready,
    input  logic [2*NUM_REQ-1:0]        req_op,
    input  logic [NUM_BITS*NUM_REQ-1:0] req_a,
    input  logic [NUM_BITS*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [NUM_BITS-1:0]         rsp_data,
    output logic                        busy,
    output logic                        div_start,
    output logic                        div_is_signed,
    output logic [NUM_BITS-1:0]         div_dividend,
    output logic [NUM_BITS-1:0]         div_divisor,
    input  logic [NUM_BITS-1:0]         div_quotient,
    input  logic [NUM_BITS-1:0]         div_remainder,
    input  logic                        div_finished
);

    localparam int unsigned ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_BITS-1:0] MIN_NEG = {1'b1, {(NUM_BITS-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t              state;
    logic [ID_W-1:0]     rr_ptr;
    logic [ID_W-1:0]     id_q;
    logic                want_rem;
    logic                guard;

    logic                cache_valid;
    logic                cache_signed;
    logic [NUM_BITS-1:0] cache_a;
    logic [NUM_BITS-1:0] cache_b;
    logic [NUM_BITS-1:0] cache_quo;
    logic [NUM_BITS-1:0] cache_rem;

    logic                grant_found;
    logic [ID_W-1:0]     grant_id;
    logic [1:0]          op_sel;
    logic [NUM_BITS-1:0] a_sel;
    logic [NUM_BITS-1:0] b_sel;
    logic                sel_signed;
    logic                is_div0;
    logic                is_ovf;
    logic                cache_hit;
    logic                handshake;

    function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base, input int unsigned off);
        int unsigned s;
        s = 32'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    function automatic logic [NUM_REQ-1:0] id_onehot(input logic [ID_W-1:0] id);
        return {{(NUM_REQ-1){1'b0}}, 1'b1} << id;
    endfunction

    // First valid requester at or after rr_ptr, wrapping
    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[wrap_add(rr_ptr, i)]) begin
                grant_found = 1'b1;
                grant_id    = wrap_add(rr_ptr, i);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && grant_found) req_ready = id_onehot(grant_id);
    end

    assign handshake  = (state == IDLE) && grant_found;
    assign op_sel     = req_op[grant_id*2 +: 2];
    assign a_sel      = req_a[grant_id*NUM_BITS +: NUM_BITS];
    assign b_sel      = req_b[grant_id*NUM_BITS +: NUM_BITS];
    assign sel_signed = ~op_sel[0];
    assign is_div0    = (b_sel == '0);
    assign is_ovf     = sel_signed && (a_sel == MIN_NEG) && (b_sel == '1);
    assign cache_hit  = cache_valid && (cache_a == a_sel) && (cache_b == b_sel) &&
                        (cache_signed == sel_signed);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            rr_ptr        <= '0;
            id_q          <= '0;
            want_rem      <= 1'b0;
            guard         <= 1'b0;
            cache_valid   <= 1'b0;
            cache_signed  <= 1'b0;
            cache_a       <= '0;
            cache_b       <= '0;
            cache_quo     <= '0;
            cache_rem     <= '0;
            div_start     <= 1'b0;
            div_is_signed <= 1'b0;
            div_dividend  <= '0;
            div_divisor   <= '0;
            rsp_valid     <= '0;
            rsp_data      <= '0;
            busy          <= 1'b0;
        end else begin
            div_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (handshake) begin
                        id_q     <= grant_id;
                        want_rem <= op_sel[1];
                        busy     <= 1'b1;
                        // Corner cases and cache hits answer next cycle without the divider
                        if (is_div0) begin
                            rsp_data  <= op_sel[1] ? a_sel : '1;
                            rsp_valid <= id_onehot(grant_id);
                            state     <= RESP;
                        end else if (is_ovf) begin
                            rsp_data  <= op_sel[1] ? '0 : a_sel;
                            rsp_valid <= id_onehot(grant_id);
                            state     <= RESP;
                        end else if (cache_hit) begin
                            rsp_data  <= op_sel[1] ? cache_rem : cache_quo;
                            rsp_valid <= id_onehot(grant_id);
                            state     <= RESP;
                        end else begin
                            div_start     <= 1'b1;
                            div_dividend  <= a_sel;
                            div_divisor   <= b_sel;
                            div_is_signed <= sel_signed;
                            state         <= START;
                        end
                    end
                end
                START: begin
                    guard <= 1'b1;
                    state <= WAIT;
                end
                WAIT: begin
                    // Divider still shows the stale finished level in the first WAIT cycle
                    guard <= 1'b0;
                    if (!guard && div_finished) begin
                        cache_valid  <= 1'b1;
                        cache_a      <= div_dividend;
                        cache_b      <= div_divisor;
                        cache_signed <= div_is_signed;
                        cache_quo    <= div_quotient;
                        cache_rem    <= div_remainder;
                        rsp_data     <= want_rem ? div_remainder : div_quotient;
                        rsp_valid    <= id_onehot(id_q);
                        state        <= RESP;
                    end
                end
                RESP: begin
                    if (|(rsp_valid & rsp_ready)) begin
                        rsp_valid <= '0;
                        rr_ptr    <= wrap_add(id_q, 1);
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_div_arbiter.sv
// Self-checking bench for div_arbiter: behavioural divider model plus an
// arithmetic reference for results, latency, arbitration order and the reuse cache.
module tb_div_arbiter;

    localparam int unsigned NB = 32;
    localparam int unsigned NR = 2;
    localparam logic [NB-1:0] MIN_NEG = 32'h8000_0000;

    logic              CLK = 1'b0;
    logic              RST;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [2*NR-1:0]   req_op;
    logic [NB*NR-1:0]  req_a;
    logic [NB*NR-1:0]  req_b;
    logic [NR-1:0]     rsp_valid;
    logic [NR-1:0]     rsp_ready;
    logic [NB-1:0]     rsp_data;
    logic              busy;
    logic              div_start;
    logic              div_is_signed;
    logic [NB-1:0]     div_dividend;
    logic [NB-1:0]     div_divisor;
    logic [NB-1:0]     div_quotient;
    logic [NB-1:0]     div_remainder;
    logic              div_finished;

    int n_assert;
    int n_fail;

    // Reference model state
    int          m_ptr;
    bit          m_cv;
    logic [NB-1:0] m_ca, m_cb;
    bit          m_cs;

    always #5 CLK = ~CLK;

    div_arbiter #(.NUM_BITS(NB), .NUM_REQ(NR)) dut (
        .CLK(CLK), .RST(RST),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .busy(busy), .div_start(div_start), .div_is_signed(div_is_signed),
        .div_dividend(div_dividend), .div_divisor(div_divisor),
        .div_quotient(div_quotient), .div_remainder(div_remainder),
        .div_finished(div_finished)
    );

    // RISC-V M semantics: returns {remainder, quotient}
    function automatic logic [2*NB-1:0] ref_qr(input bit s, input logic [NB-1:0] a, input logic [NB-1:0] b);
        logic [NB-1:0] q, r;
        if (b == '0) begin
            q = '1; r = a;
        end else if (s && a == MIN_NEG && b == '1) begin
            q = a; r = '0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {r, q};
    endfunction

    function automatic logic [NB-1:0] ref_result(input logic [1:0] op, input logic [NB-1:0] a, input logic [NB-1:0] b);
        logic [2*NB-1:0] t;
        t = ref_qr(~op[0], a, b);
        return op[1] ? t[2*NB-1:NB] : t[NB-1:0];
    endfunction

    // Divider: finished drops one edge after start, rises 17 edges after start is sampled
    int unsigned div_cnt;
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            div_cnt       <= 0;
            div_finished  <= 1'b1;
            div_quotient  <= '0;
            div_remainder <= '0;
        end else if (div_start) begin
            div_cnt <= 17;
        end else if (div_cnt != 0) begin
            div_cnt <= div_cnt - 1;
            if (div_cnt == 17) div_finished <= 1'b0;
            if (div_cnt == 1) begin
                div_finished <= 1'b1;
                {div_remainder, div_quotient} <= ref_qr(div_is_signed, div_dividend, div_divisor);
            end
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int id, input logic [1:0] op, input logic [NB-1:0] a,
                           input logic [NB-1:0] b, input bit v);
        req_op[2*id +: 2] = op;
        req_a[NB*id +: NB] = a;
        req_b[NB*id +: NB] = b;
        req_valid[id]      = v;
    endtask

    // Take the next grant, follow it to the response and complete the handshake
    task automatic serve(input int bp, input bit drop);
        int w, g, lat, starts;
        logic [1:0] op;
        logic [NB-1:0] a, b, exp_data;
        bit s, exp_div;
        logic [NR-1:0] ohot;
        #1;
        w = 0;
        while (req_ready == '0 && w < 50) begin
            @(negedge CLK); #1; w++;
        end
        check("grant_timeout", 64'(w < 50), 64'd1);
        g = -1;
        for (int k = 0; k < NR; k++) begin
            int c;
            c = (m_ptr + k) % NR;
            if (g < 0 && req_valid[c]) g = c;
        end
        if (g < 0) g = 0;
        ohot = '0;
        ohot[g] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(ohot));
        op = req_op[2*g +: 2];
        a  = req_a[NB*g +: NB];
        b  = req_b[NB*g +: NB];
        s  = ~op[0];
        exp_data = ref_result(op, a, b);
        exp_div  = !(b == '0 || (s && a == MIN_NEG && b == '1) ||
                     (m_cv && m_ca == a && m_cb == b && m_cs == s));
        if (bp > 0) rsp_ready[g] = 1'b0;
        @(posedge CLK);
        @(negedge CLK);
        if (drop) req_valid[g] = 1'b0;
        lat = 1;
        starts = 0;
        check("busy_after_hs", 64'(busy), 64'd1);
        check("div_start_t1", 64'(div_start), 64'(exp_div));
        if (exp_div) begin
            check("div_dividend", 64'(div_dividend), 64'(a));
            check("div_divisor", 64'(div_divisor), 64'(b));
            check("div_is_signed", 64'(div_is_signed), 64'(s));
        end
        while (rsp_valid == '0 && lat < 40) begin
            if (div_start) starts++;
            @(negedge CLK);
            lat++;
        end
        check("rsp_latency", 64'(lat), exp_div ? 64'd20 : 64'd1);
        check("div_start_count", 64'(starts), exp_div ? 64'd1 : 64'd0);
        check("rsp_valid", 64'(rsp_valid), 64'(ohot));
        check("rsp_data", 64'(rsp_data), 64'(exp_data));
        if (exp_div) begin
            m_cv = 1'b1; m_ca = a; m_cb = b; m_cs = s;
        end
        for (int k = 0; k < bp; k++) begin
            @(negedge CLK);
            check("bp_rsp_valid", 64'(rsp_valid), 64'(ohot));
            check("bp_rsp_data", 64'(rsp_data), 64'(exp_data));
            check("bp_no_grant", 64'(req_ready), 64'd0);
            check("bp_no_start", 64'(div_start), 64'd0);
        end
        rsp_ready[g] = 1'b1;
        @(negedge CLK);
        check("rsp_cleared", 64'(rsp_valid), 64'd0);
        m_ptr = (g + 1) % NR;
    endtask

    task automatic do_op(input int id, input logic [1:0] op, input logic [NB-1:0] a,
                         input logic [NB-1:0] b, input int bp);
        set_req(id, op, a, b, 1'b1);
        serve(bp, 1'b1);
    endtask

    initial begin
        logic [NB-1:0] ra, rb;
        int w;
        bit seen;
        n_assert = 0; n_fail = 0;
        m_ptr = 0; m_cv = 1'b0; m_ca = '0; m_cb = '0; m_cs = 1'b0;
        RST = 1'b1;
        req_valid = '0; req_op = '0; req_a = '0; req_b = '0;
        rsp_ready = '1;
        ra = 32'd1; rb = 32'd1;

        // Reset values
        repeat (2) @(negedge CLK);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_div_start", 64'(div_start), 64'd0);
        check("rst_div_signed", 64'(div_is_signed), 64'd0);
        check("rst_dividend", 64'(div_dividend), 64'd0);
        check("rst_divisor", 64'(div_divisor), 64'd0);
        RST = 1'b0;
        @(negedge CLK);
        check("idle_no_ready", 64'(req_ready), 64'd0);

        // Directed: divided op, cache hit, signed, corner cases
        do_op(0, 2'd1, 32'd100, 32'd7, 0);
        do_op(0, 2'd3, 32'd100, 32'd7, 0);
        do_op(0, 2'd0, 32'hFFFF_FF9C, 32'd7, 0);
        do_op(0, 2'd2, 32'hFFFF_FF9C, 32'd7, 0);
        do_op(0, 2'd0, 32'd5, 32'd0, 0);
        do_op(0, 2'd2, 32'd5, 32'd0, 0);
        do_op(1, 2'd0, MIN_NEG, 32'hFFFF_FFFF, 0);
        do_op(1, 2'd2, MIN_NEG, 32'hFFFF_FFFF, 0);

        // Both requesters hold valid: grants alternate, backpressure blocks the other
        set_req(0, 2'd1, 32'd1000, 32'd3, 1'b1);
        set_req(1, 2'd2, 32'hFFFF_FC18, 32'd7, 1'b1);
        serve(5, 1'b0);
        serve(0, 1'b0);
        serve(0, 1'b0);
        serve(0, 1'b0);
        req_valid = '0;

        // Randomized ops with corner cases and repeated operands
        for (int i = 0; i < 40; i++) begin
            case ($urandom % 6)
                0: begin ra = $urandom; rb = '0; end
                1: begin ra = MIN_NEG; rb = '1; end
                2: ; // reuse previous operands
                3: begin ra = $urandom; rb = $urandom_range(1, 20); end
                default: begin ra = $urandom; rb = $urandom; end
            endcase
            do_op(int'($urandom % NR), 2'($urandom), ra, rb, int'($urandom % 3));
        end

        // Reset in the middle of WAIT abandons the op and invalidates the cache
        do_op(0, 2'd1, 32'd123457, 32'd11, 0);
        set_req(0, 2'd1, 32'd999, 32'd13, 1'b1);
        #1;
        w = 0;
        while (req_ready == '0 && w < 50) begin
            @(negedge CLK); #1; w++;
        end
        check("rstwait_grant", 64'(req_ready), 64'd1);
        @(posedge CLK);
        @(negedge CLK);
        req_valid = '0;
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        #1;
        check("midrst_busy", 64'(busy), 64'd0);
        check("midrst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("midrst_rsp_data", 64'(rsp_data), 64'd0);
        check("midrst_div_start", 64'(div_start), 64'd0);
        check("midrst_dividend", 64'(div_dividend), 64'd0);
        check("midrst_divisor", 64'(div_divisor), 64'd0);
        check("midrst_signed", 64'(div_is_signed), 64'd0);
        check("midrst_ready", 64'(req_ready), 64'd0);
        m_cv = 1'b0;
        m_ptr = 0;
        @(negedge CLK);
        RST = 1'b0;
        seen = 1'b0;
        repeat (25) begin
            @(negedge CLK);
            if (rsp_valid != '0 || busy) seen = 1'b1;
        end
        check("midrst_no_response", 64'(seen), 64'd0);
        do_op(0, 2'd1, 32'd123457, 32'd11, 0);
        do_op(0, 2'd1, 32'd999, 32'd13, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
# div_arbiter

Shares one radix-4 iterative divider between `NUM_REQ` requesters (integer pipe, debug/CSR path) and sequences it.

- Ops are RISC-V M-extension DIV/DIVU/REM/REMU.
- The block arbitrates round-robin and drives the divider's start/operand pins.
- It resolves divide-by-zero and signed overflow locally, without starting the divider.
- It returns the companion result of the last division without recomputing.

## Interface
Parameters:
- `NUM_BITS`, 32, operand/result width
- `NUM_REQ`, 2, number of requesters (2..4)

Ports:
- `CLK` in 1, clock
- `RST` in 1, asynchronous, active-high reset
- `req_valid` in NUM_REQ, per-requester request valid
- `req_ready` out NUM_REQ, per-requester accept (one-hot or zero)
- `req_op` in 2*NUM_REQ, op per requester: 0 DIV, 1 DIVU, 2 REM, 3 REMU
- `req_a` in NUM_BITS*NUM_REQ, dividend per requester
- `req_b` in NUM_BITS*NUM_REQ, divisor per requester
- `rsp_valid` out NUM_REQ, one-hot result valid
- `rsp_ready` in NUM_REQ, per-requester result accept
- `rsp_data` out NUM_BITS, result (shared)
- `busy` out 1, state != IDLE
- `div_start` out 1, one-cycle divider start pulse
- `div_is_signed` out 1, divider signed mode
- `div_dividend` out NUM_BITS, divider operand
- `div_divisor` out NUM_BITS, divider operand
- `div_quotient` in NUM_BITS, divider result
- `div_remainder` in NUM_BITS, divider result
- `div_finished` in 1, divider done level

## Operation
- **State machine:** IDLE, START, WAIT, RESP.
- **IDLE:**
  - The grant goes to the first valid requester at or after `rr_ptr` (wrapping).
  - `req_ready[grant]` = 1, combinational from `req_valid` and state.
  - On handshake, latch op, a, b and id.
  - `signed` = ~op[0].
  - `want_rem` = op[1].
- **Special cases:** checked in the handshake cycle from the raw operands; the next state is RESP.
  - b == 0: quotient = all ones, remainder = a.
  - signed and a == 1<<(NUM_BITS-1) and b == all ones: quotient = a, remainder = 0.
- **Reuse cache:** holds valid, a, b, signed, quotient and remainder of the last divider run.
  - A hit (valid and all three match) goes straight to RESP with the cached value.
  - Special cases never write the cache.
- **Otherwise:** go to START.
- **START:**
  - `div_start` = 1 for exactly one cycle.
  - `div_dividend`/`div_divisor`/`div_is_signed` come from registered operands and stay stable until RESP.
  - Next state is WAIT.
- **WAIT:**
  - `div_finished` is ignored in the first WAIT cycle (guard bit), because the divider clears finished one edge after start.
  - On `div_finished` = 1 (guard clear): capture quotient and remainder into the result register and the cache (cache valid = 1), then go to RESP.
- **RESP:**
  - `rsp_valid[id]` = 1.
  - `rsp_data` = remainder if `want_rem`, else quotient.
  - Both are held stable until `rsp_ready[id]`.
  - On that handshake: `rr_ptr` = id+1 mod NUM_REQ, then go to IDLE.
- **Fairness:** a requester never waits more than NUM_REQ-1 grants.
- **Requester obligation:** a requester must hold valid and operands until ready. Dropping valid before grant is legal and simply loses arbitration.

## Timing
- **Reset values:**
  - State IDLE, `rr_ptr` 0, cache invalid.
  - `div_start` 0, `div_is_signed` 0, operands 0.
  - `rsp_valid` 0, `rsp_data` 0, `busy` 0.
  - `req_ready` 0 whenever no `req_valid` is set.
- **Reset mid-operation:** the state is abandoned with no response, and the cache is invalidated. The divider's own reset is assumed concurrent.
- **Divided ops:** handshake at cycle T.
  - `div_start` at T+1.
  - Divider counts 16 iterations; `div_finished` rises at T+19.
  - `rsp_valid` at T+20.
- **Special case or cache hit:** `rsp_valid` at T+1.
- **Back-to-back:** a new grant is possible in the cycle after the RESP handshake. There is no request acceptance while `busy`.
- **Simultaneous requests:** resolved purely by `rr_ptr`. A `req_valid` rising during RESP is not granted until IDLE.
- **Response backpressure:** `rsp_ready` low holds RESP indefinitely; the divider stays idle (finished high).

## Test plan
- **Unsigned DIVU, requester 0:** a=100, b=7 -> `div_start` at T+1, `rsp_valid[0]` at T+20, `rsp_data`=14.
- **Cache hit:** REMU a=100, b=7 immediately after the above -> no `div_start`, `rsp_valid` at T+1, `rsp_data`=2.
- **Signed DIV:** a=-100 (0xFFFFFF9C), b=7 -> `rsp_data`=0xFFFFFFF2 (-14). REM on the same operands -> 0xFFFFFFFE (-2), via cache.
- **Special cases:**
  - DIV a=5, b=0 -> 0xFFFFFFFF at T+1.
  - REM a=5, b=0 -> 5.
  - DIV a=0x80000000, b=0xFFFFFFFF -> 0x80000000.
  - REM on the same operands -> 0.
  - None of these pulse `div_start`.
- **Arbitration:** both requesters hold valid continuously with distinct ops -> grants alternate 0,1,0,1. With `rsp_ready` low for 5 cycles, `rsp_data` is held and no second grant occurs.
- **Reset mid-WAIT:** `RST` pulsed at T+10 -> all outputs at reset values, no `rsp_valid`. Retrying the same op issues `div_start` (cache invalid).
